// File: rtl/tile_dispatcher.sv
// tile_dispatcher: splits a raster-order IMG_W x IMG_H image into four quadrant tile streams.
// Optional feature macro TILE_SOF_CHECK_EN: a mid-frame sof restarts the frame and pulses err_sof.
module tile_dispatcher #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64,
   parameter int PIX_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic             in_sof,
   input  logic [3:0]       tile_full,
   output logic [3:0]       tile_wr_en,
   output logic [PIX_W-1:0] tile_data,
   output logic [3:0]       pe_start,
   output logic             frame_done,
`ifdef TILE_SOF_CHECK_EN
   output logic             err_sof,
`endif
   output logic             busy
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_col;
   logic [RW-1:0]    r_row;
   logic [3:0]       r_wr_en;
   logic [3:0]       r_pe_start;
   logic [PIX_W-1:0] r_data;
   logic             r_frame_done;
`ifdef TILE_SOF_CHECK_EN
   logic             r_err_sof;
`endif

   logic [1:0]       w_q;
   logic [3:0]       w_q_onehot;
   logic             w_ready;
   logic             w_xfer;
   logic             w_last_col;
   logic             w_last_row;

   // Quadrant is just the top bit of each counter since both dimensions are powers of two.
   assign w_q        = {r_row[RW-1], r_col[CW-1]};
   assign w_q_onehot = 4'b0001 << w_q;
   assign w_last_col = &r_col;
   assign w_last_row = &r_row;

   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         IDLE:    w_ready = 1'b1;
         RUN:     w_ready = ~tile_full[w_q];
         default: w_ready = 1'b0;
      endcase
   end

   assign in_ready = reset & w_ready;
   assign w_xfer   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_col        <= '0;
         r_row        <= '0;
         r_wr_en      <= '0;
         r_pe_start   <= '0;
         r_data       <= '0;
         r_frame_done <= 1'b0;
`ifdef TILE_SOF_CHECK_EN
         r_err_sof    <= 1'b0;
`endif
      end else begin
         r_wr_en      <= '0;
         r_frame_done <= 1'b0;
`ifdef TILE_SOF_CHECK_EN
         r_err_sof    <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_xfer && in_sof) begin
                  r_wr_en    <= 4'b0001;
                  r_data     <= in_pixel;
                  r_col      <= CW'(1);
                  r_row      <= '0;
                  r_pe_start <= '0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               // Bit 0 comes back one cycle after sof so the PEs see a clean start edge.
               r_pe_start <= r_pe_start | 4'b0001 | (w_xfer ? w_q_onehot : 4'b0000);
               if (w_xfer) begin
                  r_wr_en <= w_q_onehot;
                  r_data  <= in_pixel;
                  r_col   <= r_col + 1'b1;
                  if (w_last_col) begin
                     r_row <= r_row + 1'b1;
                     if (w_last_row) begin
                        r_state <= DONE;
                     end
                  end
`ifdef TILE_SOF_CHECK_EN
                  if (in_sof) begin
                     r_wr_en    <= 4'b0001;
                     r_col      <= CW'(1);
                     r_row      <= '0;
                     r_pe_start <= '0;
                     r_err_sof  <= 1'b1;
                     r_state    <= RUN;
                  end
`endif
               end
            end
            DONE: begin
               r_frame_done <= 1'b1;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tile_wr_en = r_wr_en;
   assign tile_data  = r_data;
   assign pe_start   = r_pe_start;
   assign frame_done = r_frame_done;
   assign busy       = (r_state != IDLE);
`ifdef TILE_SOF_CHECK_EN
   assign err_sof    = r_err_sof;
`endif

endmodule

// File: tb/tb_tile_dispatcher.sv
// tb_tile_dispatcher: directed and randomized frames checked against a pixel-index reference model.
// Honours TILE_SOF_CHECK_EN to exercise the mid-frame sof restart.
module tb_tile_dispatcher;

   localparam int IMG_W = 64;
   localparam int IMG_H = 64;
   localparam int PIX_W = 8;
   localparam int NPIX  = IMG_W * IMG_H;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [PIX_W-1:0] in_pixel;
   logic             in_sof;
   logic [3:0]       tile_full;
   logic [3:0]       tile_wr_en;
   logic [PIX_W-1:0] tile_data;
   logic [3:0]       pe_start;
   logic             frame_done;
   logic             busy;
`ifdef TILE_SOF_CHECK_EN
   logic             err_sof;
`endif

   tile_dispatcher #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pixel   (in_pixel),
      .in_sof     (in_sof),
      .tile_full  (tile_full),
      .tile_wr_en (tile_wr_en),
      .tile_data  (tile_data),
      .pe_start   (pe_start),
      .frame_done (frame_done),
`ifdef TILE_SOF_CHECK_EN
      .err_sof    (err_sof),
`endif
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int               vectors;
   int               miscompares;
   int               mPhase;     // 0 idle, 1 running, 2 done
   int               mIdx;       // raster index of the next pixel of the frame
   logic [3:0]       mPe;
   bit               mPending;
   logic [PIX_W-1:0] mData;
   int               obsCount[4];

   function automatic int targetQ(input int idx);
      return (((idx / IMG_W) >= IMG_H / 2) ? 2 : 0) + (((idx % IMG_W) >= IMG_W / 2) ? 1 : 0);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; the model advances on the same edge and all outputs are compared.
   task automatic applyStimulus(input logic v, input logic [PIX_W-1:0] px, input logic s,
                                input logic [3:0] f, input logic rst);
      logic       expReady;
      logic       xfer;
      logic [3:0] expWr;
      logic       expFd;
      logic       expErr;
      int         q;
      in_valid  = v;
      in_pixel  = px;
      in_sof    = s;
      tile_full = f;
      reset     = rst;
      #1;
      expReady = rst && (mPhase == 0 || (mPhase == 1 && !f[targetQ(mIdx)]));
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expReady});
      xfer = v && expReady;
      @(posedge clk);
      #1;
      expWr  = 4'b0000;
      expFd  = 1'b0;
      expErr = 1'b0;
      if (!rst) begin
         mPhase = 0; mIdx = 0; mPe = 4'b0000; mPending = 1'b0; mData = '0;
      end else begin
         case (mPhase)
            0: begin
               if (xfer && s) begin
                  expWr = 4'b0001; mData = px; mIdx = 1; mPe = 4'b0000; mPending = 1'b1; mPhase = 1;
               end
            end
            1: begin
               if (mPending) begin
                  mPe[0] = 1'b1; mPending = 1'b0;
               end
               if (xfer) begin
                  q = targetQ(mIdx);
                  expWr = 4'b0001 << q;
                  mData = px;
                  mPe[q] = 1'b1;
                  mIdx++;
                  if (mIdx == NPIX) begin
                     mIdx = 0; mPhase = 2;
                  end
`ifdef TILE_SOF_CHECK_EN
                  if (s) begin
                     expWr = 4'b0001; mIdx = 1; mPe = 4'b0000; mPending = 1'b1; mPhase = 1; expErr = 1'b1;
                  end
`endif
               end
            end
            default: begin
               expFd = 1'b1; mPhase = 0;
            end
         endcase
      end
      checkOutput("tile_wr_en", {28'b0, tile_wr_en}, {28'b0, expWr});
      if (expWr != 4'b0000 || !rst)
         checkOutput("tile_data", {24'b0, tile_data}, {24'b0, mData});
      checkOutput("frame_done", {31'b0, frame_done}, {31'b0, expFd});
      checkOutput("busy", {31'b0, busy}, {31'b0, (mPhase != 0)});
      checkOutput("pe_start", {28'b0, pe_start}, {28'b0, mPe});
`ifdef TILE_SOF_CHECK_EN
      checkOutput("err_sof", {31'b0, err_sof}, {31'b0, expErr});
`else
      if (expErr) checkOutput("err_sof_model", 32'd0, 32'd1);
`endif
      for (int k = 0; k < 4; k++) obsCount[k] += int'(tile_wr_en[k]);
   endtask

   task automatic finishFrame(input bit randomFull);
      int         budget;
      logic [3:0] f;
      budget = 20000;
      while (mPhase != 0 && budget > 0) begin
         f = (randomFull && $urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         applyStimulus(($urandom_range(0, 4) != 0), PIX_W'($urandom), 1'b0, f, 1'b1);
         budget--;
      end
      checkOutput("frameTimeout", mPhase, 0);
   endtask

   task automatic clearCounts();
      for (int k = 0; k < 4; k++) obsCount[k] = 0;
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      mPhase = 0; mIdx = 0; mPe = 4'b0000; mPending = 1'b0; mData = '0;
      clearCounts();

      // Reset held low with valid high, then released.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, PIX_W'($urandom), 1'b0, 4'b0000, 1'b0);
      checkOutput("rstWrEn", {28'b0, tile_wr_en}, 32'd0);
      applyStimulus(1'b0, '0, 1'b0, 4'b0000, 1'b1);

      // Full frame with (row ^ col) pattern, no stalls.
      clearCounts();
      for (int i = 0; i < NPIX; i++) begin
         applyStimulus(1'b1, PIX_W'((i / IMG_W) ^ (i % IMG_W)), (i == 0), 4'b0000, 1'b1);
         if (i == 2079) checkOutput("peBefore2080", {28'b0, pe_start}, 32'h7);
         if (i == 2080) checkOutput("peAt2080", {28'b0, pe_start}, 32'hF);
      end
      applyStimulus(1'b0, '0, 1'b0, 4'b0000, 1'b1);
      checkOutput("frameDone4096", {31'b0, frame_done}, 32'd1);
      for (int k = 0; k < 4; k++) checkOutput($sformatf("fifo%0dCount", k), obsCount[k], 1024);
      applyStimulus(1'b0, '0, 1'b0, 4'b0000, 1'b1);
      checkOutput("peHeldIdle", {28'b0, pe_start}, 32'hF);

      // Stall on quadrant 1 at (32,0), then a randomized remainder.
      applyStimulus(1'b1, PIX_W'($urandom), 1'b1, 4'b0000, 1'b1);
      checkOutput("peClearedOnSof", {28'b0, pe_start}, 32'd0);
      for (int i = 1; i < 32; i++) applyStimulus(1'b1, PIX_W'($urandom), 1'b0, 4'b0000, 1'b1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, PIX_W'($urandom), 1'b0, 4'b0010, 1'b1);
      applyStimulus(1'b1, 8'hA5, 1'b0, 4'b1101, 1'b1);
      checkOutput("resumeQ1", {28'b0, tile_wr_en}, 32'h2);
      checkOutput("resumeData", {24'b0, tile_data}, 32'hA5);
      finishFrame(1'b1);

      // Junk before sof is dropped, then a frame abandoned by reset at pixel 1500.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, PIX_W'($urandom), 1'b0, 4'b0000, 1'b1);
      checkOutput("junkBusy", {31'b0, busy}, 32'd0);
      applyStimulus(1'b1, 8'h3C, 1'b1, 4'b0000, 1'b1);
      checkOutput("sofAfterJunk", {28'b0, tile_wr_en}, 32'h1);
      for (int i = 1; i < 1500; i++) applyStimulus(1'b1, PIX_W'($urandom), 1'b0, 4'b0000, 1'b1);
      applyStimulus(1'b1, PIX_W'($urandom), 1'b0, 4'b0000, 1'b0);
      checkOutput("peDroppedOnReset", {28'b0, pe_start}, 32'd0);
      clearCounts();
      for (int i = 0; i < NPIX; i++) applyStimulus(1'b1, PIX_W'($urandom), (i == 0), 4'b0000, 1'b1);
      finishFrame(1'b0);
      checkOutput("q0AfterReset", obsCount[0], 1024);

      // Sof at pixel 700 mid-frame.
      for (int i = 0; i < 700; i++) applyStimulus(1'b1, PIX_W'($urandom), (i == 0), 4'b0000, 1'b1);
      applyStimulus(1'b1, 8'h77, 1'b1, 4'b0000, 1'b1);
`ifdef TILE_SOF_CHECK_EN
      checkOutput("errSofPulse", {31'b0, err_sof}, 32'd1);
      checkOutput("restartQ0", {28'b0, tile_wr_en}, 32'h1);
      for (int i = 1; i < NPIX; i++) applyStimulus(1'b1, PIX_W'($urandom), 1'b0, 4'b0000, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 4'b0000, 1'b1);
      checkOutput("doneAfterRestart", {31'b0, frame_done}, 32'd1);
`else
      checkOutput("sofIgnoredQ1", {28'b0, tile_wr_en}, 32'h2);
`endif
      finishFrame(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
